vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HD, default 640, horizontal active pixels.
REQ-002 SHALL have parameter HFP, default 16, horizontal front porch (pixels after active, before sync).
REQ-003 SHALL have parameter HSW, default 96, horizontal sync width.
REQ-004 SHALL have parameter HBP, default 48, horizontal back porch.
REQ-005 SHALL have parameters VD=480, VFP=10, VSW=2, VBP=33; vertical equivalents, in lines.
REQ-006 SHALL have parameters HPOL=0 and VPOL=0; 0 means sync active-low, 1 means active-high.
REQ-007 SHALL have parameter DIV, default 4, clk cycles per pixel; legal range 1..16.
REQ-008 SHALL have parameter CW, default 10, counter/coordinate width; must hold HTOT-1 and VTOT-1.
REQ-009 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-low (0 = reset).
REQ-011 SHALL have port en, input, 1, timing run enable; when low, all counters hold.
REQ-012 SHALL have ports hsync and vsync, output, 1 each, registered sync with polarity per HPOL/VPOL.
REQ-013 SHALL have port video_on, output, 1, high while pixel_x<HD and pixel_y<VD.
REQ-014 SHALL have port p_tick, output, 1, pixel enable strobe.
REQ-015 SHALL have ports pixel_x and pixel_y, output, CW each, current h/v counter values.
REQ-016 SHALL have ports line_start and frame_start, output, 1 each, single-clk strobes.

Function
REQ-017 SHALL define HTOT=HD+HFP+HSW+HBP and VTOT=VD+VFP+VSW+VBP (defaults 800, 525).
REQ-018 SHALL have a divider count 0..DIV-1 that advances when en=1 and wraps DIV-1->0; p_tick=1 exactly when count==DIV-1 and en=1; DIV=1 gives p_tick=en.
REQ-019 SHALL advance h counter on p_tick, wrap HTOT-1->0; v counter advances on p_tick with h==HTOT-1, wrap VTOT-1->0.
REQ-020 SHALL, when en=0, freeze divider, h and v counters, and sync registers, with p_tick=0; resume from the same state when en returns to 1.
REQ-021 SHALL register sync one clk after counters: sync active when h in [HD+HFP, HD+HFP+HSW-1] (defaults 656..751), v in [VD+VFP, VD+VFP+VSW-1] (490..491).
REQ-022 SHALL drive video_on, pixel_x, pixel_y combinationally from counter registers (no added latency).
REQ-023 SHALL assert line_start=p_tick && h==0, frame_start=p_tick && h==0 && v==0.
REQ-024 SHALL perform all counter increments modulo 2^CW with explicit wrap compare; no truncation warnings on width-CW arithmetic.

Reset
REQ-025 SHALL, while reset=0, clear divider, h and v counters to 0, and set hsync/vsync to inactive level (~HPOL, ~VPOL).
REQ-026 SHALL produce p_tick=0, line_start=0, frame_start=0 and video_on=1 during reset; asynchronous assertion mid-frame takes effect immediately.
REQ-027 SHALL produce the first p_tick DIV clk edges after reset deassertion with en=1, with frame_start coincident.

Structure
REQ-028 SHALL place 640x480@60 timing constants and a polarity helper in shared package vga_pkg.
REQ-029 SHALL implement the divider as sub-module pix_tick_div (params DIV; ports clk, reset, en, tick).
REQ-030 SHALL be in the 120-400 line RTL range, no latches, no derived clocks.

Verification
REQ-031 SHALL verify defaults, en=1: p_tick period 4 clk; full frame 1,680,000 clk between frame_start pulses.
REQ-032 SHALL verify hsync falls one clk after pixel_x becomes 656 and stays low 96 p_ticks; vsync low for lines 490-491 only.
REQ-033 SHALL verify HPOL=1,VPOL=1: syncs idle low, pulse high at same positions; reset drives both low.
REQ-034 SHALL verify en low at pixel_x=100 for 37 clk: pixel_x, divider, syncs unchanged; resume yields pixel_x=101 after DIV-remaining clocks.
REQ-035 SHALL verify reset asserted at (x=400,y=300): outputs go to reset values immediately; after release frame_start at 4th clk with x=y=0.
REQ-036 SHALL verify DIV=1, HD=4,HFP=1,HSW=2,HBP=1,VD=2,VFP=1,VSW=1,VBP=1: HTOT=8, frame 40 clk, x wraps 7->0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 timing constants and sync-polarity helper shared by
//             the VGA timing generator and its pixel divider.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // Horizontal timing in pixels
   localparam int H_DISP  = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;

   // Vertical timing in lines
   localparam int V_DISP  = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;

   // 25 MHz pixel rate from a 100 MHz system clock
   localparam int PIX_DIV = 4;
   localparam int COORD_W = 10;

   // Converts "inside sync window" into the electrical pin level
   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pix_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : pix_tick_div
//  Purpose  : Divides the system clock into a one-clk pixel enable strobe.
//             The phase counter only advances while en is high.
//  Revision : 1.0 - initial release
// ============================================================================
module pix_tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   // Phase counter 0..DIV-1, frozen while en is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

   // Gated by reset so DIV=1 cannot strobe while held in reset
   assign tick = en & reset & (count == LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parameterised VGA raster timing: pixel strobe, h/v counters,
//             registered syncs, active-video flag and line/frame strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen import vga_pkg::*; #(
   parameter int HD   = H_DISP,
   parameter int HFP  = H_FP,
   parameter int HSW  = H_SYNC,
   parameter int HBP  = H_BP,
   parameter int VD   = V_DISP,
   parameter int VFP  = V_FP,
   parameter int VSW  = V_SYNC,
   parameter int VBP  = V_BP,
   parameter bit HPOL = 1'b0,
   parameter bit VPOL = 1'b0,
   parameter int DIV  = PIX_DIV,
   parameter int CW   = COORD_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          p_tick,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int HTOT = HD + HFP + HSW + HBP;
   localparam int VTOT = VD + VFP + VSW + VBP;

   localparam logic [CW-1:0] H_LAST   = CW'(HTOT - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(VTOT - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(HD);
   localparam logic [CW-1:0] V_ACT    = CW'(VD);
   localparam logic [CW-1:0] HS_FIRST = CW'(HD + HFP);
   localparam logic [CW-1:0] HS_LAST  = CW'(HD + HFP + HSW - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(VD + VFP);
   localparam logic [CW-1:0] VS_LAST  = CW'(VD + VFP + VSW - 1);

   logic [CW-1:0] h_count;
   logic [CW-1:0] v_count;
   logic          h_in_sync;
   logic          v_in_sync;

   pix_tick_div #(
      .DIV (DIV)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .tick  (p_tick)
   );

   // Raster position: h steps per pixel, v steps at the end of each line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (p_tick) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + CW'(1);
         end else begin
            h_count <= h_count + CW'(1);
         end
      end
   end

   assign h_in_sync = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
   assign v_in_sync = (v_count >= VS_FIRST) && (v_count <= VS_LAST);

   // Syncs trail the counters by one clk and freeze with them when en is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync <= ~HPOL;
         vsync <= ~VPOL;
      end else if (en) begin
         hsync <= sync_level(h_in_sync, HPOL);
         vsync <= sync_level(v_in_sync, VPOL);
      end
   end

   assign pixel_x     = h_count;
   assign pixel_y     = v_count;
   assign video_on    = (h_count < H_ACT) && (v_count < V_ACT);
   assign line_start  = p_tick && (h_count == '0);
   assign frame_start = p_tick && (h_count == '0) && (v_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench for vga_timing_gen. Three instances (default
//             640x480, a small custom mode, and a tiny DIV=1 active-high mode)
//             are driven with random enable/reset and compared each clk
//             against an arithmetic raster model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int NI = 3;
   localparam int C_HD  [NI] = '{640, 20, 4};
   localparam int C_HFP [NI] = '{16,  3,  1};
   localparam int C_HSW [NI] = '{96,  5,  2};
   localparam int C_HBP [NI] = '{48,  4,  1};
   localparam int C_VD  [NI] = '{480, 10, 2};
   localparam int C_VFP [NI] = '{10,  2,  1};
   localparam int C_VSW [NI] = '{2,   2,  1};
   localparam int C_VBP [NI] = '{33,  3,  1};
   localparam bit C_HPOL[NI] = '{1'b0, 1'b0, 1'b1};
   localparam bit C_VPOL[NI] = '{1'b0, 1'b0, 1'b1};
   localparam int C_DIV [NI] = '{4,   3,  1};

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic       tick;
      logic       ls;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   typedef obs_t [NI-1:0] trio_t;

   logic          clk = 1'b0;
   logic [NI-1:0] rst_v = '0;
   logic [NI-1:0] en_v  = '0;
   logic [NI-1:0] hs, vs, von, tick, ls, fs;
   logic [9:0]    px [NI];
   logic [9:0]    py [NI];
   trio_t         act;

   trio_t         exp_q [$];
   trio_t         exp_now;
   int            n_en [NI];
   bit            phase1 = 1'b0;
   bit            done   = 1'b0;

   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .HD(C_HD[0]), .HFP(C_HFP[0]), .HSW(C_HSW[0]), .HBP(C_HBP[0]),
      .VD(C_VD[0]), .VFP(C_VFP[0]), .VSW(C_VSW[0]), .VBP(C_VBP[0]),
      .HPOL(C_HPOL[0]), .VPOL(C_VPOL[0]), .DIV(C_DIV[0]), .CW(10)
   ) u_dut0 (
      .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .hsync(hs[0]), .vsync(vs[0]),
      .video_on(von[0]), .p_tick(tick[0]), .pixel_x(px[0]), .pixel_y(py[0]),
      .line_start(ls[0]), .frame_start(fs[0])
   );

   vga_timing_gen #(
      .HD(C_HD[1]), .HFP(C_HFP[1]), .HSW(C_HSW[1]), .HBP(C_HBP[1]),
      .VD(C_VD[1]), .VFP(C_VFP[1]), .VSW(C_VSW[1]), .VBP(C_VBP[1]),
      .HPOL(C_HPOL[1]), .VPOL(C_VPOL[1]), .DIV(C_DIV[1]), .CW(10)
   ) u_dut1 (
      .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .hsync(hs[1]), .vsync(vs[1]),
      .video_on(von[1]), .p_tick(tick[1]), .pixel_x(px[1]), .pixel_y(py[1]),
      .line_start(ls[1]), .frame_start(fs[1])
   );

   vga_timing_gen #(
      .HD(C_HD[2]), .HFP(C_HFP[2]), .HSW(C_HSW[2]), .HBP(C_HBP[2]),
      .VD(C_VD[2]), .VFP(C_VFP[2]), .VSW(C_VSW[2]), .VBP(C_VBP[2]),
      .HPOL(C_HPOL[2]), .VPOL(C_VPOL[2]), .DIV(C_DIV[2]), .CW(10)
   ) u_dut2 (
      .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .hsync(hs[2]), .vsync(vs[2]),
      .video_on(von[2]), .p_tick(tick[2]), .pixel_x(px[2]), .pixel_y(py[2]),
      .line_start(ls[2]), .frame_start(fs[2])
   );

   assign act[0] = {hs[0], vs[0], von[0], tick[0], ls[0], fs[0], px[0], py[0]};
   assign act[1] = {hs[1], vs[1], von[1], tick[1], ls[1], fs[1], px[1], py[1]};
   assign act[2] = {hs[2], vs[2], von[2], tick[2], ls[2], fs[2], px[2], py[2]};

   // Reference model: n = enabled clk edges since reset. Pixel index is n/DIV,
   // raster position follows by division; the sync register reflects the
   // position one enabled edge earlier.
   function automatic obs_t model(input int i, input int n, input bit e, input bit r);
      obs_t o;
      int   htot, vtot, p, x, y, ps, xs, ys;
      bit   hact, vact;
      htot = C_HD[i] + C_HFP[i] + C_HSW[i] + C_HBP[i];
      vtot = C_VD[i] + C_VFP[i] + C_VSW[i] + C_VBP[i];
      p    = n / C_DIV[i];
      x    = p % htot;
      y    = (p / htot) % vtot;
      o.x    = 10'(x);
      o.y    = 10'(y);
      o.von  = (x < C_HD[i]) && (y < C_VD[i]);
      o.tick = r && e && ((n % C_DIV[i]) == C_DIV[i] - 1);
      o.ls   = o.tick && (x == 0);
      o.fs   = o.ls && (y == 0);
      hact = 1'b0;
      vact = 1'b0;
      if (n > 0) begin
         ps   = (n - 1) / C_DIV[i];
         xs   = ps % htot;
         ys   = (ps / htot) % vtot;
         hact = (xs >= C_HD[i] + C_HFP[i]) && (xs < C_HD[i] + C_HFP[i] + C_HSW[i]);
         vact = (ys >= C_VD[i] + C_VFP[i]) && (ys < C_VD[i] + C_VFP[i] + C_VSW[i]);
      end
      o.hs = hact ? C_HPOL[i] : ~C_HPOL[i];
      o.vs = vact ? C_VPOL[i] : ~C_VPOL[i];
      return o;
   endfunction

   // One clk of stimulus: inputs change at negedge, expectation is queued,
   // and the enabled-edge count advances at the following posedge
   task automatic step(input logic [NI-1:0] r, input logic [NI-1:0] e);
      trio_t t;
      @(negedge clk);
      rst_v = r;
      en_v  = e;
      for (int i = 0; i < NI; i++) begin
         if (!r[i]) n_en[i] = 0;
         t[i] = model(i, n_en[i], e[i], r[i]);
      end
      exp_q.push_back(t);
      @(posedge clk);
      for (int i = 0; i < NI; i++)
         if (r[i] && e[i]) n_en[i] = n_en[i] + 1;
   endtask

   // Stimulus
   initial begin
      logic [NI-1:0] r, e;
      for (int i = 0; i < NI; i++) n_en[i] = 0;
      repeat (3) step('0, '1);
      phase1 = 1'b1;
      repeat (3400) step('1, '1);
      phase1 = 1'b0;
      repeat (37) step('1, 3'b110);
      for (int k = 0; k < 20000; k++) begin
         for (int i = 0; i < NI; i++) begin
            r[i] = ($urandom_range(0, 2999) != 0);
            e[i] = ($urandom_range(0, 7) != 0);
         end
         step(r, e);
      end
      repeat (4) step('1, '1);
      done = 1'b1;
   end

   // Monitor: pops one expectation per clk and compares all instances;
   // while en is continuously high it also measures tick and frame periods
   initial begin
      obs_t a, x;
      int   cyc;
      int   last_tick [NI];
      int   last_frame[NI];
      int   htot, vtot;
      cyc = 0;
      for (int i = 0; i < NI; i++) begin
         last_tick[i]  = -1;
         last_frame[i] = -1;
      end
      while (!(done && exp_q.size() == 0)) begin
         @(negedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
               a = act[i];
               x = exp_now[i];
               n_checks++;
               if (a !== x) begin
                  n_fail++;
                  $display("FAIL inst%0d outputs cyc=%0d: got hs=%b vs=%b von=%b tick=%b ls=%b fs=%b x=%0d y=%0d, required hs=%b vs=%b von=%b tick=%b ls=%b fs=%b x=%0d y=%0d",
                           i, cyc, a.hs, a.vs, a.von, a.tick, a.ls, a.fs, a.x, a.y,
                           x.hs, x.vs, x.von, x.tick, x.ls, x.fs, x.x, x.y);
               end
            end
         end
         if (phase1) begin
            for (int i = 0; i < NI; i++) begin
               htot = C_HD[i] + C_HFP[i] + C_HSW[i] + C_HBP[i];
               vtot = C_VD[i] + C_VFP[i] + C_VSW[i] + C_VBP[i];
               if (tick[i]) begin
                  if (last_tick[i] >= 0) begin
                     n_checks++;
                     if (cyc - last_tick[i] != C_DIV[i]) begin
                        n_fail++;
                        $display("FAIL inst%0d tick_period: got %0d clk, required %0d",
                                 i, cyc - last_tick[i], C_DIV[i]);
                     end
                  end
                  last_tick[i] = cyc;
               end
               if (fs[i]) begin
                  if (last_frame[i] >= 0) begin
                     n_checks++;
                     if (cyc - last_frame[i] != htot * vtot * C_DIV[i]) begin
                        n_fail++;
                        $display("FAIL inst%0d frame_period: got %0d clk, required %0d",
                                 i, cyc - last_frame[i], htot * vtot * C_DIV[i]);
                     end
                  end
                  last_frame[i] = cyc;
               end
            end
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
